mips_run_dump_controller: RTL and testbench

- Parametrised run-and-dump controller for the MIPS core.
- Gates the core with a clock enable for a bounded run.
- The run ends on a core halt indication or on a cycle limit.
- It then streams the register file and data memory out over a valid/ready port, for bench capture or debug export.
- Sits between the test environment and mips_core; replaces hand-counted clock toggles and end-of-run file dumps.

---
 rtl/mips_run_dump_controller.sv | 95 +++++++++
 tb/tb_mips_run_dump_controller.sv | 119 +++++++++++
 2 files changed

// File: rtl/mips_run_dump_controller.sv
// mips_run_dump_controller: gates the core for a bounded run, then streams registers and memory out
module mips_run_dump_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int MAX_CYCLES = 1024,
   localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
   localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  core_halt,
   output logic                  core_en,
   output logic [RW-1:0]         reg_rd_addr,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   output logic [MW-1:0]         mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_is_mem,
   output logic [31:0]           dump_index,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [31:0]           cycle_count
);
   typedef enum logic [2:0] {IDLE, RUN, DUMP_REG, DUMP_MEM, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] idx_q, idx_d, cycle_q, cycle_d;
   logic        timeout_q, timeout_d;
   logic        in_reg, in_mem, xfer;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cycle_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cycle_q   <= cycle_d;
         timeout_q <= timeout_d;
      end
   end
   always_comb begin
      in_reg      = state_q == DUMP_REG;
      in_mem      = state_q == DUMP_MEM;
      core_en     = state_q == RUN;
      busy        = core_en || in_reg || in_mem;
      done        = state_q == DONE;
      dump_valid  = in_reg || in_mem;
      dump_is_mem = in_mem;
      dump_index  = dump_valid ? idx_q : '0;
      reg_rd_addr = in_reg ? idx_q[RW-1:0] : '0;
      mem_rd_addr = in_mem ? idx_q[MW-1:0] : '0;
      dump_data   = in_reg ? reg_rd_data : in_mem ? mem_rd_data : '0;
      timeout     = timeout_q;
      cycle_count = cycle_q;
      xfer        = dump_valid && dump_ready;
   end
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cycle_d   = cycle_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d   = RUN;
            cycle_d   = '0;
            timeout_d = 1'b0;
         end
         RUN: begin
            cycle_d = cycle_q + 32'd1;
            idx_d   = '0;
            // halt takes priority over the cycle limit
            if (core_halt) state_d = DUMP_REG;
            else if (cycle_d == 32'(MAX_CYCLES)) begin
               timeout_d = 1'b1;
               state_d   = DUMP_REG;
            end
         end
         DUMP_REG: if (xfer) begin
            idx_d   = (idx_q == 32'(REG_COUNT - 1)) ? '0 : idx_q + 32'd1;
            state_d = (idx_q == 32'(REG_COUNT - 1)) ? DUMP_MEM : DUMP_REG;
         end
         DUMP_MEM: if (xfer) begin
            idx_d   = (idx_q == 32'(MEM_DEPTH - 1)) ? '0 : idx_q + 32'd1;
            state_d = (idx_q == 32'(MEM_DEPTH - 1)) ? DONE : DUMP_MEM;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mips_run_dump_controller.sv
// tb_mips_run_dump_controller: directed run/dump scenarios with assertion-based checks
module tb_mips_run_dump_controller;
   logic        clock = 0, reset_n = 0, start = 0, core_halt = 0, dump_ready = 0;
   logic        core_en, dump_valid, dump_is_mem, busy, done, timeout;
   logic [4:0]  reg_rd_addr;
   logic [7:0]  mem_rd_addr;
   logic [31:0] reg_rd_data, mem_rd_data, dump_data, dump_index, cycle_count;
   logic [31:0] rf [32];
   logic [31:0] mem [256];
   int total = 0, fails = 0;
   always #5 clock = ~clock;
   assign reg_rd_data = rf[reg_rd_addr];
   assign mem_rd_data = mem[mem_rd_addr];
   mips_run_dump_controller #(.DATA_WIDTH(32), .REG_COUNT(32), .MEM_DEPTH(256), .MAX_CYCLES(8)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .core_halt(core_halt), .core_en(core_en),
      .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_is_mem(dump_is_mem), .dump_index(dump_index), .busy(busy),
      .done(done), .timeout(timeout), .cycle_count(cycle_count));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle();
      chk("idle_core_en", core_en, 0);
      chk("idle_valid", dump_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_cycles", cycle_count, 0);
      chk("idle_timeout", timeout, 0);
      chk("idle_index", dump_index, 0);
      chk("idle_data", dump_data, 0);
      chk("idle_raddr", reg_rd_addr, 0);
      chk("idle_maddr", mem_rd_addr, 0);
   endtask
   task automatic run(input int halt_at, input int exp_cyc, input bit exp_to, input bit bp, input int abort_at);
      int cnt = 0, k = 0, guard = 0;
      logic mem_word;
      int widx;
      start = 1;
      @(posedge clock); #1;
      start = 0;
      chk("run_busy", busy, 1);
      while (core_en && guard < 50) begin
         cnt++;
         core_halt = (cnt == halt_at);
         start = bp ? 1'($urandom % 2) : 1'b0;
         chk("run_valid", dump_valid, 0);
         @(posedge clock); #1;
         guard++;
      end
      core_halt = 0;
      start = 0;
      chk("en_cycles", cnt, exp_cyc);
      chk("cycle_count", cycle_count, exp_cyc);
      chk("timeout", timeout, exp_to);
      guard = 0;
      while (k < 288 && guard < 3000) begin
         mem_word = k >= 32;
         widx = mem_word ? k - 32 : k;
         chk("dump_valid", dump_valid, 1);
         chk("dump_is_mem", dump_is_mem, mem_word);
         chk("dump_index", dump_index, widx);
         chk("dump_data", dump_data, mem_word ? mem[widx] : rf[widx]);
         chk("reg_addr", reg_rd_addr, mem_word ? 0 : widx);
         chk("mem_addr", mem_rd_addr, mem_word ? widx : 0);
         chk("dump_core_en", core_en, 0);
         if (k == abort_at) begin
            reset_n = 0;
            dump_ready = 0;
            @(posedge clock); #1;
            chk_idle();
            reset_n = 1;
            return;
         end
         dump_ready = bp ? 1'($urandom % 2) : 1'b1;
         start = bp ? ($urandom % 4 == 0) : 1'b0;
         if (dump_ready) k++;
         @(posedge clock); #1;
         guard++;
      end
      dump_ready = 0;
      start = 0;
      chk("dump_words", k, 288);
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", dump_valid, 0);
      chk("done_cycles", cycle_count, exp_cyc);
      chk("done_timeout", timeout, exp_to);
      repeat (3) @(posedge clock);
      #1;
      chk("done_hold", done, 1);
      chk("done_hold_en", core_en, 0);
      chk("done_hold_cycles", cycle_count, exp_cyc);
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i * 32'h0013_0007;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 ^ (i * 32'h0001_0101 + 5);
      start = 1;
      repeat (2) @(posedge clock);
      #1;
      chk_idle();
      start = 0;
      reset_n = 1;
      @(posedge clock); #1;
      chk("idle_stays", busy, 0);
      run(5, 5, 0, 0, -1);
      run(0, 8, 1, 0, -1);
      run(8, 8, 0, 0, -1);
      run(6, 6, 0, 1, -1);
      run(3, 3, 0, 0, 10);
      run(2, 2, 0, 0, -1);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
